// File: rtl/music_player_if.sv
// Avalon-MM read-master bundle between the music player and the flash controller.
// The player uses the master modport; the flash side uses slave.
interface music_player_if;
  logic [22:0] flsh_address;
  logic        flsh_waitrequest;
  logic        flsh_read;
  logic [31:0] flsh_readdata;
  logic        flsh_readdatavalid;
  logic [3:0]  flsh_byteenable;

  modport master (
    output flsh_address, flsh_read, flsh_byteenable,
    input  flsh_waitrequest, flsh_readdata, flsh_readdatavalid
  );

  modport slave (
    input  flsh_address, flsh_read, flsh_byteenable,
    output flsh_waitrequest, flsh_readdata, flsh_readdatavalid
  );
endinterface

// File: rtl/music_player.sv
// Streams 16-bit samples from flash, two per 32-bit word, one per startsamplenow strobe.
// Playback direction and pause come from keyboard levels.
module music_player #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kybrd_forward,
  input  logic        kybrd_pause,
  input  logic        startsamplenow,
  music_player_if.master flsh,
  output logic [15:0] audio_data
);

  typedef enum logic [1:0] {IDLE, READ, WAIT_DATA, OUTPUT} state_t;

  state_t      state, state_nxt;
  logic [22:0] addr_q;
  logic        half_q;
  logic [31:0] data_q;

  assign flsh.flsh_address    = addr_q;
  assign flsh.flsh_byteenable = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    flsh.flsh_read = 1'b0;
    unique case (state)
      IDLE:      if (startsamplenow && !kybrd_pause) state_nxt = READ;
      READ: begin
        flsh.flsh_read = 1'b1;
        if (!flsh.flsh_waitrequest) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: if (flsh.flsh_readdatavalid) state_nxt = OUTPUT;
      OUTPUT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Backward play walks upper->lower within a word, so the word step happens on the half=0 side.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= START_ADDR;
      half_q     <= 1'b0;
      data_q     <= '0;
      audio_data <= '0;
    end else begin
      if (state == WAIT_DATA && flsh.flsh_readdatavalid)
        data_q <= flsh.flsh_readdata;
      if (state == OUTPUT) begin
        audio_data <= half_q ? data_q[31:16] : data_q[15:0];
        half_q     <= ~half_q;
        if (kybrd_forward && half_q)
          addr_q <= (addr_q == END_ADDR) ? START_ADDR : addr_q + 23'd1;
        else if (!kybrd_forward && !half_q)
          addr_q <= (addr_q == START_ADDR) ? END_ADDR : addr_q - 23'd1;
      end
    end
  end

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a hand-driven flash responder.
module tb_music_player;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kybrd_forward = 1'b1;
  logic        kybrd_pause = 1'b0;
  logic        startsamplenow = 1'b0;
  logic [15:0] audio_data;
  int          n_tests = 0;
  int          n_fail = 0;

  music_player_if bus ();

  music_player #(.START_ADDR(23'h000000), .END_ADDR(23'h07FFFF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .kybrd_forward  (kybrd_forward),
    .kybrd_pause    (kybrd_pause),
    .startsamplenow (startsamplenow),
    .flsh           (bus.master),
    .audio_data     (audio_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    startsamplenow = 1'b1;
    tick();
    startsamplenow = 1'b0;
  endtask

  // One full sample: strobe, accept the read, answer after delay cycles, check output.
  task automatic play(input string tag, input logic [31:0] word, input logic [22:0] exp_addr,
                      input logic [15:0] exp_audio, input int delay);
    strobe();
    check({tag, "_read_hi"}, 32'(bus.flsh_read), 32'd1);
    check({tag, "_addr"}, 32'(bus.flsh_address), 32'(exp_addr));
    tick();
    check({tag, "_read_lo"}, 32'(bus.flsh_read), 32'd0);
    repeat (delay) tick();
    bus.flsh_readdata = word;
    bus.flsh_readdatavalid = 1'b1;
    tick();
    bus.flsh_readdatavalid = 1'b0;
    bus.flsh_readdata = '0;
    tick();
    check({tag, "_audio"}, 32'(audio_data), 32'(exp_audio));
  endtask

  initial begin
    bus.flsh_waitrequest = 1'b0;
    bus.flsh_readdata = '0;
    bus.flsh_readdatavalid = 1'b0;

    tick();
    check("rst_read", 32'(bus.flsh_read), 32'd0);
    check("rst_addr", 32'(bus.flsh_address), 32'd0);
    check("rst_audio", 32'(audio_data), 32'd0);
    check("byteenable", 32'(bus.flsh_byteenable), 32'hF);
    rst_n = 1'b1;
    tick();

    play("fwd0", 32'hdeadbeef, 23'd0, 16'hbeef, 20);
    play("fwd1", 32'hdeadbeef, 23'd0, 16'hdead, 20);
    check("fwd_addr_next", 32'(bus.flsh_address), 32'd1);

    // Waitrequest held for 5 cycles at address 1, lower half.
    bus.flsh_waitrequest = 1'b1;
    strobe();
    for (int i = 0; i < 5; i++) begin
      check("wr_read_held", 32'(bus.flsh_read), 32'd1);
      check("wr_addr_held", 32'(bus.flsh_address), 32'd1);
      tick();
    end
    bus.flsh_waitrequest = 1'b0;
    check("wr_read_last", 32'(bus.flsh_read), 32'd1);
    tick();
    check("wr_read_drop", 32'(bus.flsh_read), 32'd0);
    repeat (3) tick();
    bus.flsh_readdata = 32'h12345678;
    bus.flsh_readdatavalid = 1'b1;
    tick();
    bus.flsh_readdatavalid = 1'b0;
    tick();
    check("wr_audio", 32'(audio_data), 32'h5678);

    // Busy drop: extra strobe during WAIT_DATA, upper half of word 1.
    strobe();
    check("busy_read", 32'(bus.flsh_read), 32'd1);
    tick();
    repeat (2) tick();
    strobe();
    check("busy_no_read", 32'(bus.flsh_read), 32'd0);
    bus.flsh_readdata = 32'hcafef00d;
    bus.flsh_readdatavalid = 1'b1;
    tick();
    bus.flsh_readdatavalid = 1'b0;
    tick();
    check("busy_audio", 32'(audio_data), 32'hcafe);
    for (int i = 0; i < 4; i++) begin
      check("busy_idle", 32'(bus.flsh_read), 32'd0);
      tick();
    end
    check("busy_addr", 32'(bus.flsh_address), 32'd2);

    // Pause: strobe ignored, position and output frozen.
    kybrd_pause = 1'b1;
    strobe();
    for (int i = 0; i < 3; i++) begin
      check("pause_no_read", 32'(bus.flsh_read), 32'd0);
      tick();
    end
    check("pause_audio", 32'(audio_data), 32'hcafe);
    check("pause_addr", 32'(bus.flsh_address), 32'd2);
    kybrd_pause = 1'b0;
    play("resume", 32'h11112222, 23'd2, 16'h2222, 2);

    // Reset in the middle of a read, then a stray readdatavalid in IDLE.
    strobe();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_read", 32'(bus.flsh_read), 32'd0);
    check("mid_rst_addr", 32'(bus.flsh_address), 32'd0);
    check("mid_rst_audio", 32'(audio_data), 32'd0);
    bus.flsh_readdata = 32'h55556666;
    bus.flsh_readdatavalid = 1'b1;
    tick();
    bus.flsh_readdatavalid = 1'b0;
    repeat (3) tick();
    check("stray_audio", 32'(audio_data), 32'd0);
    check("stray_read", 32'(bus.flsh_read), 32'd0);

    // Backward from START_ADDR/half=0 wraps to END_ADDR.
    kybrd_forward = 1'b0;
    play("bwd0", 32'haaaabbbb, 23'd0, 16'hbbbb, 3);
    check("bwd_wrap_addr", 32'(bus.flsh_address), 32'h07FFFF);
    play("bwd1", 32'h99998888, 23'h07FFFF, 16'h9999, 1);
    check("bwd_addr_hold", 32'(bus.flsh_address), 32'h07FFFF);

    // Forward from END_ADDR wraps to START_ADDR after the upper half.
    kybrd_forward = 1'b1;
    play("fwdw0", 32'h77776666, 23'h07FFFF, 16'h6666, 1);
    play("fwdw1", 32'h77776666, 23'h07FFFF, 16'h7777, 1);
    check("fwd_wrap_addr", 32'(bus.flsh_address), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
